// File: rtl/ffd_pipe_pkg.sv
// Shared constants and helpers for the ffd_pipe delay line.
// Build option FFD_PIPE_PARITY_EN adds a per-stage even-parity bit.
package ffd_pkg;

   localparam int FFD_WIDTH_DEF = 8;
   localparam int FFD_DEPTH_DEF = 4;

   // Width of an occupancy counter able to hold 0..depth inclusive.
   function automatic int ffd_cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/ffd_pipe_if.sv
// Control, data and status bundle of the ffd_pipe delay line.
// Under FFD_PIPE_PARITY_EN it also carries par_inj and par_err.
interface ffd_pipe_if
   import ffd_pkg::*;
#(
   parameter int WIDTH = FFD_WIDTH_DEF,
   parameter int DEPTH = FFD_DEPTH_DEF
);
   localparam int CW = ffd_cnt_w(DEPTH);

   logic             en;
   logic             flush;
   logic [WIDTH-1:0] dato;
   logic             dato_vld;
   logic [WIDTH-1:0] q;
   logic             q_vld;
   logic [CW-1:0]    cnt;
   logic             full;
   logic             empty;

`ifdef FFD_PIPE_PARITY_EN
   logic             par_inj;
   logic             par_err;

   modport master (
      output en, flush, dato, dato_vld, par_inj,
      input  q, q_vld, cnt, full, empty, par_err
   );

   modport slave (
      input  en, flush, dato, dato_vld, par_inj,
      output q, q_vld, cnt, full, empty, par_err
   );
`else
   modport master (
      output en, flush, dato, dato_vld,
      input  q, q_vld, cnt, full, empty
   );

   modport slave (
      input  en, flush, dato, dato_vld,
      output q, q_vld, cnt, full, empty
   );
`endif

endinterface

// File: rtl/ffd_pipe_stage.sv
// One pipeline stage: data word, valid bit and, under FFD_PIPE_PARITY_EN,
// a parity bit. Priority per edge is flush, then en, then hold.
module ffd_stage
   import ffd_pkg::*;
#(
   parameter int               WIDTH   = FFD_WIDTH_DEF,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             flush,
   input  logic [WIDTH-1:0] d,
   input  logic             d_vld,
`ifdef FFD_PIPE_PARITY_EN
   input  logic             par_d,
   output logic             par_q,
`endif
   output logic [WIDTH-1:0] q,
   output logic             q_vld
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q     <= RST_VAL;
         q_vld <= 1'b0;
      end else if (flush) begin
         q     <= RST_VAL;
         q_vld <= 1'b0;
      end else if (en) begin
         q     <= d;
         q_vld <= d_vld;
      end
   end

`ifdef FFD_PIPE_PARITY_EN
   // Cleared stages hold the matching parity of RST_VAL so they never alarm.
   localparam logic RST_PAR = ^RST_VAL;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         par_q <= RST_PAR;
      end else if (flush) begin
         par_q <= RST_PAR;
      end else if (en) begin
         par_q <= par_d;
      end
   end
`endif

endmodule

// File: rtl/ffd_pipe.sv
// WIDTH-bit, DEPTH-stage delay line with stall, flush and occupancy count.
// Build option FFD_PIPE_PARITY_EN adds per-stage parity with par_inj/par_err.
module ffd_pipe
   import ffd_pkg::*;
#(
   parameter int               WIDTH   = FFD_WIDTH_DEF,
   parameter int               DEPTH   = FFD_DEPTH_DEF,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic        clk,
   input  logic        rst_n,
   ffd_pipe_if.slave   bus
);
   localparam int CW = ffd_cnt_w(DEPTH);

   logic [WIDTH-1:0] data_arr [DEPTH];
   logic             vld_arr  [DEPTH];
`ifdef FFD_PIPE_PARITY_EN
   logic             par_arr  [DEPTH];
`endif

   logic [CW-1:0]    cnt_reg;
   logic [CW-1:0]    cnt_next;

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_stage
         logic [WIDTH-1:0] d_in;
         logic             v_in;
`ifdef FFD_PIPE_PARITY_EN
         logic             p_in;
`endif
         if (gi == 0) begin : g_head
            assign d_in = bus.dato;
            assign v_in = bus.dato_vld;
`ifdef FFD_PIPE_PARITY_EN
            // par_inj flips the captured parity so a checker downstream can be exercised.
            assign p_in = (^bus.dato) ^ bus.par_inj;
`endif
         end else begin : g_body
            assign d_in = data_arr[gi-1];
            assign v_in = vld_arr[gi-1];
`ifdef FFD_PIPE_PARITY_EN
            assign p_in = par_arr[gi-1];
`endif
         end

         ffd_stage #(
            .WIDTH   (WIDTH),
            .RST_VAL (RST_VAL)
         ) u_stage (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (bus.en),
            .flush (bus.flush),
            .d     (d_in),
            .d_vld (v_in),
`ifdef FFD_PIPE_PARITY_EN
            .par_d (p_in),
            .par_q (par_arr[gi]),
`endif
            .q     (data_arr[gi]),
            .q_vld (vld_arr[gi])
         );
      end
   endgenerate

   // Entry and exit on the same enabled edge cancel; the count tracks the valid popcount.
   always_comb begin
      cnt_next = cnt_reg;
      if (bus.flush) begin
         cnt_next = '0;
      end else if (bus.en) begin
         case ({bus.dato_vld, vld_arr[DEPTH-1]})
            2'b10:   cnt_next = cnt_reg + CW'(1);
            2'b01:   cnt_next = cnt_reg - CW'(1);
            default: cnt_next = cnt_reg;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_next;
      end
   end

   assign bus.q     = data_arr[DEPTH-1];
   assign bus.q_vld = vld_arr[DEPTH-1];
   assign bus.cnt   = cnt_reg;
   assign bus.full  = (cnt_reg == CW'(DEPTH));
   assign bus.empty = (cnt_reg == '0);

`ifdef FFD_PIPE_PARITY_EN
   assign bus.par_err = vld_arr[DEPTH-1] & ((^data_arr[DEPTH-1]) ^ par_arr[DEPTH-1]);
`endif

endmodule

// File: tb/tb_ffd_pipe.sv
// Randomised and directed bench for ffd_pipe (DEPTH=4 and DEPTH=1 instances),
// checked against a queue-based history model of accepted words.
module tb_ffd_pipe;

   localparam int               W      = 8;
   localparam int               D      = 4;
   localparam logic [W-1:0]     RV     = 8'h00;
   localparam logic [W-1:0]     RV1    = 8'hC3;

   typedef struct {
      logic [W-1:0] d;
      logic         v;
      logic         inj;
   } ent_t;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;
   int   cyc;

   ent_t         hist[$];
   logic [W-1:0] exp1_q;
   logic         exp1_v;
   logic         cur_inj;

   ffd_pipe_if #(.WIDTH(W), .DEPTH(D)) bus  ();
   ffd_pipe_if #(.WIDTH(W), .DEPTH(1)) bus1 ();

   ffd_pipe #(.WIDTH(W), .DEPTH(D), .RST_VAL(RV)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   ffd_pipe #(.WIDTH(W), .DEPTH(1), .RST_VAL(RV1)) u_dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d got=0x%0h expected=0x%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic model_clear();
      hist.delete();
      for (int i = 0; i < D; i++) hist.push_back('{RV, 1'b0, 1'b0});
      exp1_q = RV1;
      exp1_v = 1'b0;
   endtask

   function automatic int exp_cnt();
      int n = 0;
      foreach (hist[i]) n += int'(hist[i].v);
      return n;
   endfunction

   // Reflects one rising edge: the word seen at q is the one accepted DEPTH enabled edges ago.
   task automatic model_update();
      if (!rst_n || bus.flush) begin
         hist.delete();
         for (int i = 0; i < D; i++) hist.push_back('{RV, 1'b0, 1'b0});
      end else if (bus.en) begin
         hist.push_back('{bus.dato, bus.dato_vld, cur_inj});
         void'(hist.pop_front());
      end
      if (!rst_n || bus1.flush) begin
         exp1_q = RV1;
         exp1_v = 1'b0;
      end else if (bus1.en) begin
         exp1_q = bus1.dato;
         exp1_v = bus1.dato_vld;
      end
   endtask

   task automatic compare_all();
      int c;
      c = exp_cnt();
      check("q",      32'(bus.q),     32'(hist[0].d));
      check("q_vld",  32'(bus.q_vld), 32'(hist[0].v));
      check("cnt",    32'(bus.cnt),   32'(c));
      check("full",   32'(bus.full),  32'(c == D));
      check("empty",  32'(bus.empty), 32'(c == 0));
      check("d1_q",   32'(bus1.q),     32'(exp1_q));
      check("d1_vld", 32'(bus1.q_vld), 32'(exp1_v));
      check("d1_cnt", 32'(bus1.cnt),   32'(exp1_v));
`ifdef FFD_PIPE_PARITY_EN
      check("par_err",    32'(bus.par_err),  32'(hist[0].v & hist[0].inj));
      check("d1_par_err", 32'(bus1.par_err), 32'(0));
`endif
   endtask

   task automatic drive(input logic en, input logic fl, input logic [W-1:0] d,
                        input logic v, input logic inj);
      bus.en       = en;
      bus.flush    = fl;
      bus.dato     = d;
      bus.dato_vld = v;
      cur_inj      = inj;
`ifdef FFD_PIPE_PARITY_EN
      bus.par_inj  = inj;
      bus1.par_inj = 1'b0;
`endif
      bus1.en       = ($urandom_range(0, 3) != 0);
      bus1.flush    = ($urandom_range(0, 15) == 0);
      bus1.dato     = W'($urandom);
      bus1.dato_vld = 1'($urandom);
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      @(negedge clk);
      cyc++;
      compare_all();
      $display("cyc=%0d rst_n=%0b en=%0b flush=%0b dato=%02h vld=%0b -> q=%02h q_vld=%0b cnt=%0d",
               cyc, rst_n, bus.en, bus.flush, bus.dato, bus.dato_vld, bus.q, bus.q_vld, bus.cnt);
   endtask

   logic [W-1:0] seq [5];
   logic [W-1:0] rv_tmp;

   initial begin
      checks   = 0;
      failures = 0;
      cyc      = 0;
      rst_n    = 1'b0;
      model_clear();
      seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33; seq[3] = 8'h44; seq[4] = 8'h55;

      // Reset held while input is offered: nothing may enter.
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0, 8'h99, 1'b1, 1'b0);
         step();
      end
      rst_n = 1'b1;

      // Latency: word k shows up DEPTH enabled edges after it is presented.
      for (int i = 0; i < 9; i++) begin
         drive(1'b1, 1'b0, (i < 5) ? seq[i] : 8'h00, (i < 5), 1'b0);
         step();
         if (i == 3) begin
            check("lat_q",    32'(bus.q),    32'h11);
            check("lat_full", 32'(bus.full), 32'd1);
         end
      end

      // Stall with a full pipe: nothing moves, 0xFF never reaches q.
      drive(1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
      step();
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b0, 8'hA0 + W'(i), 1'b1, 1'b0);
         step();
      end
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0, 8'hFF, 1'b1, 1'b0);
         step();
         check("stall_q", 32'(bus.q), 32'hA0);
         check("stall_cnt", 32'(bus.cnt), 32'd4);
      end

      // Flush wins over en and drops the word offered alongside it.
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0, 8'hB0 + W'(i), 1'b1, 1'b0);
         step();
      end
      drive(1'b1, 1'b1, 8'h77, 1'b1, 1'b0);
      step();
      rv_tmp = RV;
      check("flush_cnt",   32'(bus.cnt),   32'd0);
      check("flush_empty", 32'(bus.empty), 32'd1);
      check("flush_q",     32'(bus.q),     32'(rv_tmp));
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
         step();
         check("flush_no77", 32'(bus.q == 8'h77), 32'd0);
      end

      // Bubbles: alternating valids stay alternating, occupancy stays 1..2.
      drive(1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
      step();
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 1'b0, 8'hC0 + W'(i), (i % 2 == 0), 1'b0);
         step();
         if (i >= 3 && i <= 6) check("bubble_vld", 32'(bus.q_vld), 32'((i - 3) % 2 == 0));
         if (i >= 1) check("bubble_cnt_rng", 32'(bus.cnt >= 1 && bus.cnt <= 2), 32'd1);
      end

      // Asynchronous reset between edges clears state at once.
      drive(1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
      step();
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 1'b0, 8'hD0 + W'(i), 1'b1, 1'b0);
         step();
      end
      check("pre_rst_cnt", 32'(bus.cnt), 32'd2);
      #1 rst_n = 1'b0;
      #1;
      check("arst_vld",   32'(bus.q_vld), 32'd0);
      check("arst_cnt",   32'(bus.cnt),   32'd0);
      check("arst_empty", 32'(bus.empty), 32'd1);
      check("arst_d1_q",  32'(bus1.q),    32'(RV1));
      model_clear();
      @(negedge clk);
      rst_n = 1'b1;

`ifdef FFD_PIPE_PARITY_EN
      // Injected parity error is reported exactly while that word is valid at q.
      for (int k = 0; k < 2; k++) begin
         drive(1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
         step();
         drive(1'b1, 1'b0, 8'h5A, 1'b1, (k == 0));
         step();
         for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
            step();
            if (i == 2) check("par_hit", 32'(bus.par_err), 32'(k == 0));
         end
      end
`endif

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0),
               W'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0));
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
